max_unpool1: RTL
================

Name: max_unpool1

Overview:
- Inverse of the 2x2/stride-2 max-pool stage.
- Takes NUM_MAPS pooled maps of size IN_DIM x IN_DIM plus a 2-bit argmax code per element.
- Scatters each pooled value back into its source position in a 2*IN_DIM x 2*IN_DIM map and zero-fills the other three positions of each window.
- Sits on the decoder/backward side of the pool stage; uses the same array-in/array-out start/done framing as the other layer blocks.

Parameters:
- NUM_MAPS, 16, number of feature maps.
- IN_DIM, 14, pooled map height/width; output dimension is OUT_DIM = 2*IN_DIM (28).
- DATA_W, 32, signed element width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin one unpool pass; sampled only in IDLE.
- busy  output  1  high while in UNPOOL.
- done  output  1  one-cycle pulse when all outputs are valid.
- pooled_maps  input  signed DATA_W x [NUM_MAPS][IN_DIM][IN_DIM]  values to scatter.
- argmax  input  2 x [NUM_MAPS][IN_DIM][IN_DIM]  window position code: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
- unpooled_maps  output  signed DATA_W x [NUM_MAPS][OUT_DIM][OUT_DIM]  scattered result.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0; done=0.
  - Counters f, i, j = 0.
  - Every unpooled_maps element = 0.
  - Reset asserted mid-pass aborts immediately; after release the block sits in IDLE and does not resume.
- States: IDLE, UNPOOL, DONE.
  - IDLE -> UNPOOL when start=1.
  - UNPOOL -> DONE on the cycle that processes f=NUM_MAPS-1, i=IN_DIM-1, j=IN_DIM-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- UNPOOL processes one pooled element (f,i,j) per cycle. For v = pooled_maps[f][i][j] and a = argmax[f][i][j], the block writes all four window cells [f][2i+r][2j+c] with r,c in {0,1}:
  - The cell where 2r+c == a gets v.
  - The other three cells get 0.
  - All four writes land on the same clock edge.
- Scan order: j fastest, then i, then f; j and i wrap IN_DIM-1 -> 0.
- Counter widths: f is $clog2(NUM_MAPS) bits, i/j are $clog2(IN_DIM) bits. Index arithmetic (2i+1, 2j+1) is computed at $clog2(OUT_DIM) width so no truncation occurs at i or j = IN_DIM-1.
- Every output cell is written exactly once per pass, so no clear phase is needed. Cells not yet visited hold their previous-pass values until overwritten.
- No arithmetic on data: values are copied bit-exact; negative values and 0 are passed unchanged.
- Latency:
  - start sampled on edge 0; first write on edge 1.
  - Last write on edge NUM_MAPS*IN_DIM*IN_DIM (3136).
  - done=1 during the following cycle (DONE state).
- busy=1 exactly in UNPOOL.
- done is registered: it rises on entry to DONE and falls on the next edge.
- start while in UNPOOL or DONE is ignored; there is no queueing.
- start held high continuously produces back-to-back passes separated by the single DONE cycle plus one IDLE cycle.
- pooled_maps and argmax must be held stable from start until done. The block does not latch them.
- unpooled_maps holds its values after done until the next pass overwrites them.

Optional Feature:
- Macro: MAX_UNPOOL1_NEAREST_EN.
- Defined: nearest-neighbour upsample mode. v is written to all four window cells, the argmax input is ignored, and timing is unchanged.
- Undefined: argmax scatter as described above.

Test Plan:
- Reset mid-pass: start, let 100 cycles elapse, pull reset_n low → busy=0, done=0, all outputs 0. Release reset_n and pulse start → a full pass completes normally.
- Single-value routing: pooled_maps[0][0][0]=7 with argmax=0,1,2,3 in four passes → 7 appears at [0][0][0], [0][0][1], [0][1][0], [0][1][1] respectively, and the other three cells are 0 each time.
- Boundary indices: pooled_maps[15][13][13] = -5, argmax=3 → unpooled_maps[15][27][27] = -5; [15][26][26], [15][26][27], [15][27][26] = 0.
- Latency/handshake: one start pulse → busy high for exactly 3136 cycles; done high for exactly 1 cycle, on cycle 3137 after the start edge. A start pulse at cycle 50 has no effect.
- Full random compare: random signed pooled_maps and random argmax → unpooled_maps matches the reference model for all 16x28x28 cells. Check that maxpooling the unpooled output reproduces pooled_maps wherever every pooled value is ≥ 0.
- Back-to-back: start held high for two passes with different data → second pass fully overwrites the first. MAX_UNPOOL1_NEAREST_EN build with v=9 → all four window cells equal 9 regardless of argmax.

Source files
------------

// File: rtl/max_unpool1.sv
// Inverse 2x2/stride-2 max-pool: scatters each pooled value into its argmax window cell, zeroing the rest.
// Define MAX_UNPOOL1_NEAREST_EN to replicate each value into all four cells instead (argmax ignored).
module max_unpool1 #(
  parameter int unsigned NUM_MAPS = 16,
  parameter int unsigned IN_DIM   = 14,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic signed [DATA_W-1:0] pooled_maps   [NUM_MAPS][IN_DIM][IN_DIM],
  input  logic        [1:0]        argmax        [NUM_MAPS][IN_DIM][IN_DIM],
  output logic signed [DATA_W-1:0] unpooled_maps [NUM_MAPS][2*IN_DIM][2*IN_DIM]
);

  localparam int unsigned OUT_DIM = 2 * IN_DIM;
  localparam int unsigned F_W     = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam int unsigned I_W     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned O_W     = $clog2(OUT_DIM);

  typedef enum logic [1:0] {IDLE, UNPOOL, DONE} state_t;

  state_t                    state;
  logic [F_W-1:0]            f;
  logic [I_W-1:0]            i;
  logic [I_W-1:0]            j;
  logic [O_W-1:0]            row0, row1, col0, col1;
  logic signed [DATA_W-1:0]  v;
  logic signed [DATA_W-1:0]  cell_v [4];
  logic                      last_j, last_i, last_f;

  // Window corner indices are widened before doubling so 2*(IN_DIM-1)+1 never truncates.
  always_comb begin
    row0   = O_W'(i) << 1;
    row1   = row0 | O_W'(1);
    col0   = O_W'(j) << 1;
    col1   = col0 | O_W'(1);
    v      = pooled_maps[f][i][j];
    last_j = (j == I_W'(IN_DIM - 1));
    last_i = (i == I_W'(IN_DIM - 1));
    last_f = (f == F_W'(NUM_MAPS - 1));
    for (int k = 0; k < 4; k++) begin
`ifdef MAX_UNPOOL1_NEAREST_EN
      cell_v[k] = v;
`else
      cell_v[k] = (argmax[f][i][j] == 2'(k)) ? v : '0;
`endif
    end
  end

  // Control: scan f/i/j with j fastest; busy and done are registered with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      f     <= '0;
      i     <= '0;
      j     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= UNPOOL;
            busy  <= 1'b1;
            f     <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        UNPOOL: begin
          if (last_j) begin
            j <= '0;
            if (last_i) begin
              i <= '0;
              if (last_f) begin
                f     <= '0;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                f <= f + F_W'(1);
              end
            end else begin
              i <= i + I_W'(1);
            end
          end else begin
            j <= j + I_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output map: all four cells of the current window update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int mf = 0; mf < NUM_MAPS; mf++)
        for (int mr = 0; mr < OUT_DIM; mr++)
          for (int mc = 0; mc < OUT_DIM; mc++)
            unpooled_maps[mf][mr][mc] <= '0;
    end else if (state == UNPOOL) begin
      unpooled_maps[f][row0][col0] <= cell_v[0];
      unpooled_maps[f][row0][col1] <= cell_v[1];
      unpooled_maps[f][row1][col0] <= cell_v[2];
      unpooled_maps[f][row1][col1] <= cell_v[3];
    end
  end

endmodule
